// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: pipeline stage register with valid/ready handshake and flush.
// Build option PIPE_REG_SKID_EN adds a second (skid) entry, so in_ready is
// driven from a register and has no combinational path from out_ready.
// Without it the stage holds one word and in_ready follows out_ready.
module pipe_reg_hs #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;
  logic             w_consume;

  // rst and flush both gate in_ready, so w_accept is already 0 in those cycles.
  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_valid & out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

`ifdef PIPE_REG_SKID_EN

  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready = ~r_skid_valid & ~rst & ~flush;

  // Valid bits: the only state cleared by reset or flush.
  // NOTE: reset is synchronous (sampled on posedge), and sequential state
  // uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      // Both entries full: a consume promotes skid into main, main stays valid.
      if (w_consume) r_skid_valid <= 1'b0;
    end else if (r_valid) begin
      if (w_consume)     r_valid      <= w_accept;
      else if (w_accept) r_skid_valid <= 1'b1;
    end else begin
      r_valid <= w_accept;
    end
  end

  // Main data: loads from skid on a promoting consume, else from the input
  // when the accepted word can go straight into main.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= RESET_VAL;
    end else if (r_skid_valid) begin
      if (w_consume) r_data <= r_skid_data;
    end else if (w_accept && (!r_valid || w_consume)) begin
      r_data <= in_data;
    end
  end

  // Skid data: captures a word accepted while main is stalled.
  // NOTE: payload-only storage needs no reset; r_skid_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_accept && r_valid && !w_consume) r_skid_data <= in_data;
  end

`else

  // Single entry: ready when empty or being drained this cycle.
  assign in_ready = (~r_valid | out_ready) & ~rst & ~flush;

  // Valid bit: set on accept, cleared on consume, flush or reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Main data: loads only on accept; holds across consume and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= RESET_VAL;
    end else if (w_accept) begin
      r_data <= in_data;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb_pipe_reg_hs: directed scenarios plus random valid/ready traffic, checked
// against a queue-based model of the stage (capacity 1, or 2 with
// PIPE_REG_SKID_EN). Compile with the same define as the RTL.
module tb_pipe_reg_hs;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RV    = 32'hDEAD_BEEF;
`ifdef PIPE_REG_SKID_EN
  localparam int          CAP   = 2;
`else
  localparam int          CAP   = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: words held by the stage in order, and the visible payload.
  logic [31:0] q[$];
  logic [31:0] m_data;

  always #5 clk = ~clk;

  pipe_reg_hs #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stage can take a word: not in reset/flush and has room (single entry
  // also has room if the held word leaves this cycle).
  function automatic logic m_ready();
    if (rst || flush) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    logic exp_ready;
    logic do_consume;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #2;
    exp_ready = m_ready();
    check("in_ready",  {31'b0, in_ready},  {31'b0, exp_ready});
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    check("out_data",  out_data, m_data);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_data = RV;
    end else if (f) begin
      q.delete();
    end else begin
      do_consume = (q.size() != 0) && ordy;
      if (do_consume) void'(q.pop_front());
      if (iv && exp_ready) q.push_back(d);
      if (q.size() != 0) m_data = q[0];
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    // 1. Reset value, in_ready low during reset and high after.
    @(posedge clk);
    @(negedge clk);
    q.delete();
    m_data = RV;
    step(1'b1, 1'b0, 1'b1, 32'h1234, 1'b1);
    check("t1_valid", {31'b0, out_valid}, 32'h0);
    check("t1_data",  out_data, RV);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // 2. Back-to-back stream with out_ready high.
    step(1'b0, 1'b0, 1'b1, 32'h1, 1'b1);
    check("t2_w1", out_data, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h2, 1'b1);
    check("t2_w2", out_data, 32'h2);
    step(1'b0, 1'b0, 1'b1, 32'h3, 1'b1);
    check("t2_w3", out_data, 32'h3);
    check("t2_valid", {31'b0, out_valid}, 32'h1);
    idle(2);

    // 3. Backpressure: 0xA stalls, 0xB offered, then released in order.
    step(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    check("t3_hold", out_data, 32'hA);
    step(1'b0, 1'b0, 1'b1, 32'hB, 1'b1);
    check("t3_next", out_data, 32'hB);
    idle(3);

    // 4. Flush while holding 0x55 with 0x66 offered.
    step(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h66, 1'b0);
    check("t4_valid", {31'b0, out_valid}, 32'h0);
    check("t4_data",  out_data, 32'h55);
    idle(2);

    // 5. Reset with the stage filled to capacity.
    step(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h33, 1'b0);
    check("t5_valid", {31'b0, out_valid}, 32'h0);
    check("t5_data",  out_data, RV);
    idle(3);

    // 6. Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6),
           $urandom(),
           ($urandom_range(0, 9) < 6));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
